fetch_if_stage: RTL and testbench
=================================

# fetch_if_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core. It owns the PC and drives the synchronous instruction memory, which has one cycle of read latency. It presents {pc_ID, instr_ID, valid_ID} to decode. It consumes `stall_IFID` and `flush` from the hazard unit, and uses a one-entry hold buffer so that no fetched instruction is lost while decode is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (addi x0,x0,0).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_IFID` in 1: freeze PC and the IF/ID register.
- `flush` in 1: taken branch; redirect to `branch_target` and squash the IF/ID register.
- `branch_target` in 32: redirect address; bits [1:0] are ignored and treated as 0.
- `imem_en` out 1: read strobe to instruction memory.
- `imem_addr` out 32: read address; bits [1:0] are always 0.
- `imem_rdata` in 32: data for the address issued in the previous cycle.
- `pc_ID` out 32: PC of the instruction in ID.
- `instr_ID` out 32: instruction in ID.
- `valid_ID` out 1: `instr_ID` is a real instruction, not a bubble.
- `stall_cnt` out 32: stalled cycles. Present only with `FETCH_PERF_EN`.
- `flush_cnt` out 32: flush cycles. Present only with `FETCH_PERF_EN`.

## Operation
- Internal state:
  - `pc_F`: next address to issue.
  - `req_pc` / `req_valid`: a read is in flight and returns this cycle.
  - `hold_instr` / `hold_valid`: captured response.
- Derived mode: FILL when `req_valid=0`; RUN when `req_valid=1` and `hold_valid=0`; HELD when `hold_valid=1`.
- Priority is reset > flush > stall > normal.
- **Normal** (no stall, no flush):
  - Drive `imem_en=1` and `imem_addr=pc_F`.
  - Update `pc_F<=pc_F+4`, `req_pc<=pc_F`, `req_valid<=1`.
  - If `req_valid`, the IF/ID register loads {`req_pc`, `hold_valid ? hold_instr : imem_rdata`} with `valid_ID=1`. Otherwise it loads {0, `NOP_INSTR`} with `valid_ID=0`.
  - `hold_valid<=0`.
- **Stall** (`stall_IFID=1`, `flush=0`):
  - Drive `imem_en=0`; `imem_addr` remains `pc_F`.
  - `pc_F`, `req_pc`, `req_valid` and the IF/ID register hold their values.
  - If `req_valid && !hold_valid`, capture `hold_instr<=imem_rdata` and set `hold_valid<=1` (RUN→HELD). Further stall cycles keep the buffer unchanged.
- **Flush** (`flush=1`, regardless of stall):
  - Drive `imem_en=1` and `imem_addr={branch_target[31:2],2'b00}`.
  - Update `pc_F<=target+4`, `req_pc<=target`, `req_valid<=1`, `hold_valid<=0`.
  - The IF/ID register loads {0, `NOP_INSTR`} with `valid_ID=0`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Release from HELD: the first unstalled cycle forwards `hold_instr` to ID and issues the next read in the same cycle. There is no dead cycle.

## Timing
- Reset values:
  - `pc_F=RESET_PC`, `req_valid=0`, `hold_valid=0`.
  - `pc_ID=0`, `instr_ID=NOP_INSTR`, `valid_ID=0`.
  - Perf counters are 0.
  - While `reset` is high, `imem_en=0`.
- First fetch: `RESET_PC` is issued in the first cycle after `reset` falls. Its instruction is in ID after the second rising edge.
- Steady-state throughput is one instruction per cycle. Fetch-to-ID latency is 2 edges.
- Flush latency: the instruction at the target is valid in ID 2 edges after the flush cycle. Exactly one bubble follows the flush edge.
- Reset mid-stall or mid-flush clears all state, including the hold buffer, at that edge.
- `imem_en`/`imem_addr` are combinational from state and `flush`/`stall_IFID`. All other outputs are registered.

## Configuration
- `FETCH_PERF_EN` defined:
  - `stall_cnt` increments on every non-reset cycle with `stall_IFID=1 && flush=0`.
  - `flush_cnt` increments on every non-reset cycle with `flush=1`.
  - Both wrap at 2^32 and reset to 0.
- `FETCH_PERF_EN` undefined: both ports and both counters are absent. All other behaviour is identical.

## Test plan
- **Reset release**: `RESET_PC`=0x100, memory returns addr+0xA000 → `imem_addr`=0x100, 0x104, … on consecutive cycles; ID shows (0x100, 0xA100, valid) after the 2nd edge, then (0x104, 0xA104).
- **Stall held 3 cycles mid-stream**, with the response for 0x108 returning on the first stall cycle:
  - ID holds 0x104 throughout and `imem_en=0`.
  - After release, ID shows 0x108 and then 0x10C with no gap and no duplicate.
- **Flush with `branch_target`=0x203** while in RUN:
  - `imem_addr`=0x200 in the flush cycle.
  - ID shows `valid_ID=0` with `NOP_INSTR`, then (0x200, 0xA200, valid).
- **Flush and stall in the same cycle while HELD**: flush wins, the hold buffer is discarded, and the next valid ID instruction is at the target.
- **PC wrap**: `branch_target`=0xFFFF_FFFC → ID shows 0xFFFF_FFFC then 0x0000_0000.
- **Counters** (`FETCH_PERF_EN`): 3 stall cycles and 1 flush → `stall_cnt`=3, `flush_cnt`=1. A reset mid-stall returns both counters and `valid_ID` to 0.

Source files
------------

// File: rtl/fetch_if_stage.sv
// Instruction-fetch stage with IF/ID register and a one-entry hold buffer for stalls.
// Optional FETCH_PERF_EN adds stall_cnt / flush_cnt performance counters.
module fetch_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_F;
  logic [31:0] req_pc;
  logic        req_valid;
  logic [31:0] hold_instr;
  logic        hold_valid;
  logic [31:0] target;
  logic        advance;
  logic        unused_tgt_bits;

  assign target          = {branch_target[31:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];
  assign advance         = !flush && !stall_IFID;

  // IF: request issue toward instruction memory
  assign imem_en   = !reset && (flush || !stall_IFID);
  assign imem_addr = flush ? target : pc_F;

  // Control state: PC, in-flight flag, hold flag, ID valid
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F       <= RESET_PC;
      req_valid  <= 1'b0;
      hold_valid <= 1'b0;
      valid_ID   <= 1'b0;
      pc_ID      <= 32'h0;
      instr_ID   <= NOP_INSTR;
    end else if (flush) begin
      pc_F       <= target + 32'd4;
      req_valid  <= 1'b1;
      hold_valid <= 1'b0;
      valid_ID   <= 1'b0;
      pc_ID      <= 32'h0;
      instr_ID   <= NOP_INSTR;
    end else if (stall_IFID) begin
      if (req_valid && !hold_valid)
        hold_valid <= 1'b1;
    end else begin
      pc_F       <= pc_F + 32'd4;
      req_valid  <= 1'b1;
      hold_valid <= 1'b0;
      // IF/ID: forward the held word if a stall parked it, else the live response
      if (req_valid) begin
        valid_ID <= 1'b1;
        pc_ID    <= req_pc;
        instr_ID <= hold_valid ? hold_instr : imem_rdata;
      end else begin
        valid_ID <= 1'b0;
        pc_ID    <= 32'h0;
        instr_ID <= NOP_INSTR;
      end
    end
  end

  // Datapath-only registers: qualified by req_valid / hold_valid, so no reset needed
  always_ff @(posedge clk) begin
    if (flush)
      req_pc <= target;
    else if (advance)
      req_pc <= pc_F;
    if (!flush && stall_IFID && req_valid && !hold_valid)
      hold_instr <= imem_rdata;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (flush)
        flush_cnt <= flush_cnt + 32'd1;
      else if (stall_IFID)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_if_stage.sv
// Bench for fetch_if_stage: directed scenarios then random stall/flush/reset traffic
// compared against an instruction-stream model (next PC to deliver + primed flag).
module tb_fetch_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] MEMOFF = 32'h0000_A000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_IFID = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_ID;
  logic [31:0] instr_ID;
  logic        valid_ID;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: stream of instructions delivered to ID
  logic [31:0] m_next;
  logic        m_primed;
  logic [31:0] m_pc_id;
  logic [31:0] m_instr;
  logic        m_vld;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;

  fetch_if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .reset(reset),
    .stall_IFID(stall_IFID),
    .flush(flush),
    .branch_target(branch_target),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .pc_ID(pc_ID),
    .instr_ID(instr_ID),
    .valid_ID(valid_ID)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory: one cycle latency, garbage when no read was issued
  always @(posedge clk)
    imem_rdata <= imem_en ? (imem_addr + MEMOFF) : $urandom();

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] t);
    logic [31:0] exp_addr;
    @(negedge clk);
    reset = r; stall_IFID = s; flush = f; branch_target = t;
    #1;
    if (r) begin
      chk("imem_en_reset", {31'b0, imem_en}, 32'd0);
    end else begin
      if (f) exp_addr = {t[31:2], 2'b00};
      else   exp_addr = m_primed ? m_next + 32'd4 : m_next;
      chk("imem_en", {31'b0, imem_en}, {31'b0, (f || !s)});
      chk("imem_addr", imem_addr, exp_addr);
    end
    @(posedge clk);
    if (r) begin
      m_pc_id = 0; m_instr = NOP; m_vld = 0;
      m_next = RST_PC; m_primed = 0; m_scnt = 0; m_fcnt = 0;
    end else if (f) begin
      m_pc_id = 0; m_instr = NOP; m_vld = 0;
      m_next = {t[31:2], 2'b00}; m_primed = 1; m_fcnt++;
    end else if (s) begin
      m_scnt++;
    end else if (m_primed) begin
      m_pc_id = m_next; m_instr = m_next + MEMOFF; m_vld = 1;
      m_next = m_next + 32'd4;
    end else begin
      m_pc_id = 0; m_instr = NOP; m_vld = 0; m_primed = 1;
    end
    #1;
    chk("pc_ID", pc_ID, m_pc_id);
    chk("instr_ID", instr_ID, m_instr);
    chk("valid_ID", {31'b0, valid_ID}, {31'b0, m_vld});
`ifdef FETCH_PERF_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  initial begin
    m_next = RST_PC; m_primed = 0; m_pc_id = 0; m_instr = NOP; m_vld = 0;
    m_scnt = 0; m_fcnt = 0;

    // Reset and release
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("tp_first_bubble", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("tp_first_pc", pc_ID, 32'h100);
    chk("tp_first_instr", instr_ID, 32'hA100);
    cycle(0, 0, 0, 0);
    chk("tp_second_pc", pc_ID, 32'h104);

    // Three-cycle stall with 0x108 response landing in the first stall cycle
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("tp_stall_hold_pc", pc_ID, 32'h104);
    cycle(0, 0, 0, 0);
    chk("tp_release_pc", pc_ID, 32'h108);
    chk("tp_release_instr", instr_ID, 32'hA108);
    cycle(0, 0, 0, 0);
    chk("tp_after_release_pc", pc_ID, 32'h10C);
`ifdef FETCH_PERF_EN
    chk("tp_stall_cnt3", stall_cnt, 32'd3);
`endif

    // Flush to unaligned target while running
    cycle(0, 0, 1, 32'h203);
    chk("tp_flush_instr", instr_ID, NOP);
    cycle(0, 0, 0, 0);
    chk("tp_flush_tgt_pc", pc_ID, 32'h200);
    chk("tp_flush_tgt_instr", instr_ID, 32'hA200);
`ifdef FETCH_PERF_EN
    chk("tp_flush_cnt1", flush_cnt, 32'd1);
`endif

    // Flush + stall together while HELD
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h400);
    cycle(0, 0, 0, 0);
    chk("tp_held_flush_pc", pc_ID, 32'h400);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("tp_wrap_pc0", pc_ID, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("tp_wrap_pc1", pc_ID, 32'h0000_0000);

    // Reset in the middle of a stall
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("tp_reset_mid_stall_vld", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("tp_after_reset_pc", pc_ID, RST_PC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, s, f;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 35);
      f = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom();
      cycle(r, s, f, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
